// File: rtl/tone_arbiter.sv
// Round-robin arbiter sharing one Speaker tone generator between several sound sources.
// Plays the granted tone for its full duration, then holds a fixed silent gap before serving the next request.
module tone_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FREQ_W     = 16,
  parameter int DUR_W      = 24,
  parameter int GAP_CYCLES = 50000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*FREQ_W-1:0]  req_freq,
  input  logic [NUM_REQ*DUR_W-1:0]   req_dur,
  input  logic                       abort,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic                       play,
  output logic [FREQ_W-1:0]          frequency,
  output logic                       done
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  logic [DUR_W-1:0]   r_dur_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [PTR_W-1:0]   r_ptr;
  logic [FREQ_W-1:0]  r_freq;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_done;

  state_t             w_nxt_state;
  logic [DUR_W-1:0]   w_nxt_dur;
  logic [GAP_W-1:0]   w_nxt_gap;
  logic [PTR_W-1:0]   w_nxt_ptr;
  logic [FREQ_W-1:0]  w_nxt_freq;
  logic [NUM_REQ-1:0] w_nxt_grant;
  logic               w_nxt_done;

  logic               w_any;
  logic               w_hi_found;
  logic [PTR_W-1:0]   w_lo;
  logic [PTR_W-1:0]   w_hi;
  logic [PTR_W-1:0]   w_win;
  logic [FREQ_W-1:0]  w_sel_freq;
  logic [DUR_W-1:0]   w_sel_dur;

  // Round robin: lowest set bit at or above the pointer, else wrap to the lowest set bit overall.
  always_comb begin
    w_any      = 1'b0;
    w_hi_found = 1'b0;
    w_lo       = '0;
    w_hi       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_any = 1'b1;
        w_lo  = PTR_W'(i);
        if (i >= int'(r_ptr)) begin
          w_hi_found = 1'b1;
          w_hi       = PTR_W'(i);
        end
      end
    end
    w_win      = w_hi_found ? w_hi : w_lo;
    w_sel_freq = req_freq[int'(w_win)*FREQ_W +: FREQ_W];
    w_sel_dur  = req_dur[int'(w_win)*DUR_W +: DUR_W];
  end

  always_comb begin
    // NOTE: every next-value term is defaulted first so no branch can leave it unassigned and infer a latch.
    w_nxt_state = r_state;
    w_nxt_dur   = r_dur_cnt;
    w_nxt_gap   = r_gap_cnt;
    w_nxt_ptr   = r_ptr;
    w_nxt_freq  = r_freq;
    w_nxt_grant = '0;
    w_nxt_done  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_nxt_state = S_PLAY;
          w_nxt_freq  = w_sel_freq;
          w_nxt_dur   = (w_sel_dur == '0) ? DUR_W'(1) : w_sel_dur;
          w_nxt_grant = NUM_REQ'(1) << w_win;
          w_nxt_ptr   = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);
        end
      end
      S_PLAY: begin
        if (abort) begin
          w_nxt_state = S_IDLE;
          w_nxt_freq  = '0;
          w_nxt_dur   = '0;
        end else if (r_dur_cnt == DUR_W'(1)) begin
          w_nxt_done = 1'b1;
          w_nxt_dur  = '0;
          if (GAP_CYCLES > 0) begin
            w_nxt_state = S_GAP;
            w_nxt_gap   = GAP_W'(GAP_CYCLES);
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_freq  = '0;
          end
        end else begin
          w_nxt_dur = r_dur_cnt - DUR_W'(1);
        end
      end
      S_GAP: begin
        if (abort || r_gap_cnt == GAP_W'(1)) begin
          w_nxt_state = S_IDLE;
          w_nxt_freq  = '0;
          w_nxt_gap   = '0;
        end else begin
          w_nxt_gap = r_gap_cnt - GAP_W'(1);
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates so every register sees the same pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dur_cnt <= '0;
      r_gap_cnt <= '0;
      r_ptr     <= '0;
      r_freq    <= '0;
      r_grant   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_dur_cnt <= w_nxt_dur;
      r_gap_cnt <= w_nxt_gap;
      r_ptr     <= w_nxt_ptr;
      r_freq    <= w_nxt_freq;
      r_grant   <= w_nxt_grant;
      r_done    <= w_nxt_done;
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign frequency = r_freq;
  assign play      = (r_state == S_PLAY);
  assign busy      = (r_state != S_IDLE);

endmodule
